// File: rtl/expand_queue_fifo.sv
// Narrow-to-wide buffered channel: packs IN_WIDTH beats into OUT_WIDTH words,
// queues them in a 2^ASIZE-deep FIFO and presents them on a registered valid/ready port.
module expand_queue_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 512,
  parameter int ASIZE        = 5,
  parameter bit INPUT_PORT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_WIDTH-1:0]     d_a,
  input  logic                    vld_a,
  output logic                    rdy_a,
  output logic [OUT_WIDTH-1:0]    d_b,
  output logic                    vld_b,
  input  logic                    rdy_b,
  input  logic                    is_done_mode_user,
  output logic [PAYLOAD_BITS-1:0] full_cnt,
  output logic [PAYLOAD_BITS-1:0] empty_cnt,
  output logic [PAYLOAD_BITS-1:0] read_cnt,
  output logic                    stall_condition
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [CW-1:0]           LAST    = CW'(RATIO - 1);
  localparam logic [CW-1:0]           CNT_ONE = CW'(1);
  localparam logic [ASIZE:0]          PTR_ONE = (ASIZE + 1)'(1);
  localparam logic [PAYLOAD_BITS-1:0] CTR_ONE = PAYLOAD_BITS'(1);

  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] pack;
  logic                 pack_vld;
  logic [ASIZE:0]       wr_ptr, rd_ptr;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic                 full, empty, accept, last_beat, wr_en, rd_en;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr == {~rd_ptr[ASIZE], rd_ptr[ASIZE-1:0]});
  assign rdy_a     = !pack_vld || !full;
  assign accept    = vld_a && rdy_a;
  assign last_beat = (cnt == LAST);
  assign wr_en     = pack_vld && !full;
  assign rd_en     = !empty && (rdy_b || !vld_b);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pack     <= '0;
      pack_vld <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < RATIO; i++) begin
          if (cnt == CW'(i)) pack[i*IN_WIDTH +: IN_WIDTH] <= d_a;
        end
        cnt <= last_beat ? '0 : cnt + CNT_ONE;
      end
      if (accept && last_beat) pack_vld <= 1'b1;
      else if (wr_en)          pack_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointers
  // already makes every entry unreadable, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ASIZE-1:0]] <= pack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_b   <= '0;
      vld_b <= 1'b0;
    end else if (rd_en) begin
      d_b   <= mem[rd_ptr[ASIZE-1:0]];
      vld_b <= 1'b1;
    end else if (vld_b && rdy_b) begin
      vld_b <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt  <= '0;
      empty_cnt <= '0;
      read_cnt  <= '0;
    end else if (!is_done_mode_user) begin
      if (full)           full_cnt  <= full_cnt + CTR_ONE;
      if (empty)          empty_cnt <= empty_cnt + CTR_ONE;
      if (vld_b && rdy_b) read_cnt  <= read_cnt + CTR_ONE;
    end
  end

  // Input ports stall on starvation, output ports on backpressure.
  generate
    if (INPUT_PORT) begin : g_stall_in
      assign stall_condition = !is_done_mode_user && rdy_b && empty;
    end else begin : g_stall_out
      assign stall_condition = !is_done_mode_user && vld_a && !rdy_a;
    end
  endgenerate

endmodule

// File: tb/tb_expand_queue_fifo.sv
// Scoreboard bench for expand_queue_fifo (RATIO = 4): stimulus pushes packed words,
// a negedge monitor pops and compares on every output handshake.
module tb_expand_queue_fifo;

  localparam int IW    = 32;
  localparam int OW    = 128;
  localparam int RATIO = OW / IW;
  localparam int PB    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] d_a;
  logic          vld_a, rdy_a, rdy_b, done_mode;
  logic [OW-1:0] d_b;
  logic          vld_b, stall;
  logic [PB-1:0] full_cnt, empty_cnt, read_cnt;

  logic          rdy_a2, vld_b2, stall2;
  logic [OW-1:0] d_b2;
  logic [PB-1:0] full_cnt2, empty_cnt2, read_cnt2;

  expand_queue_fifo #(.PAYLOAD_BITS(PB), .IN_WIDTH(IW), .OUT_WIDTH(OW), .ASIZE(5), .INPUT_PORT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .d_a(d_a), .vld_a(vld_a), .rdy_a(rdy_a),
    .d_b(d_b), .vld_b(vld_b), .rdy_b(rdy_b), .is_done_mode_user(done_mode),
    .full_cnt(full_cnt), .empty_cnt(empty_cnt), .read_cnt(read_cnt),
    .stall_condition(stall)
  );

  expand_queue_fifo #(.PAYLOAD_BITS(PB), .IN_WIDTH(IW), .OUT_WIDTH(OW), .ASIZE(5), .INPUT_PORT(1'b1)) dut_ip (
    .clk(clk), .rst_n(rst_n), .d_a(d_a), .vld_a(vld_a), .rdy_a(rdy_a2),
    .d_b(d_b2), .vld_b(vld_b2), .rdy_b(rdy_b), .is_done_mode_user(done_mode),
    .full_cnt(full_cnt2), .empty_cnt(empty_cnt2), .read_cnt(read_cnt2),
    .stall_condition(stall2)
  );

  always #5 clk = ~clk;

  int            n_vec  = 0;
  int            n_miss = 0;
  int            n_pop  = 0;
  int            stalls = 0;
  logic [OW-1:0] sb [$];
  logic [OW-1:0] pack_m = '0;
  int            cnt_m  = 0;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_d = '0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each handshaken word and checks d_b stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_vld", OW'(vld_b), OW'(1));
        check("hold_data", d_b, prev_d);
      end
      if (vld_b && rdy_b) begin
        check("sb_nonempty", OW'(sb.size() != 0), OW'(1));
        if (sb.size() != 0) begin
          check("word", d_b, sb.pop_front());
          n_pop++;
        end
      end
      prev_hold = vld_b && !rdy_b;
      prev_d    = d_b;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    sb.delete();
    cnt_m  = 0;
    pack_m = '0;
  endtask

  task automatic do_reset();
    vld_a = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one beat and waits (bounded) until it is accepted; updates the packing model.
  task automatic send_beat(input logic [IW-1:0] data);
    logic acc;
    int   guard;
    d_a   = data;
    vld_a = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = rdy_a;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 500);
    vld_a = 1'b0;
    if (!acc) begin
      check("accept_timeout", OW'(acc), OW'(1));
    end else begin
      pack_m[cnt_m*IW +: IW] = data;
      if (cnt_m == RATIO - 1) begin
        sb.push_back(pack_m);
        cnt_m = 0;
      end else begin
        cnt_m++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check({name, "_drained"}, OW'(sb.size()), OW'(0));
    @(posedge clk);
    #1;
  endtask

  int            p0;
  logic [PB-1:0] c0;
  bit            stop;

  initial begin
    rst_n = 1'b0; vld_a = 1'b0; d_a = '0; rdy_b = 1'b1; done_mode = 1'b0;

    // Reset state
    #12;
    check("rst_rdy_a", OW'(rdy_a), OW'(1));
    check("rst_vld_b", OW'(vld_b), OW'(0));
    check("rst_d_b", d_b, OW'(0));
    check("rst_full_cnt", OW'(full_cnt), OW'(0));
    check("rst_read_cnt", OW'(read_cnt), OW'(0));
    do_reset();
    check("post_rst_empty_cnt0", OW'(empty_cnt), OW'(0));
    check("post_rst_stall_ip", OW'(stall2), OW'(1));
    @(posedge clk); #1;
    check("post_rst_empty_cnt1", OW'(empty_cnt), OW'(1));

    // 1. Single pack
    for (int i = 1; i <= 4; i++) send_beat(IW'(i));
    check("lat_t", OW'(vld_b), OW'(0));
    @(posedge clk); #1;
    check("lat_t1", OW'(vld_b), OW'(0));
    @(posedge clk); #1;
    check("lat_t2", OW'(vld_b), OW'(1));
    check("single_d_b", d_b, 128'h00000004_00000003_00000002_00000001);
    wait_drain("single");
    check("single_read_cnt", OW'(read_cnt), OW'(1));

    // 2. Streaming
    do_reset();
    stalls = 0;
    p0 = n_pop;
    for (int i = 0; i < 400; i++) send_beat(32'h2000_0000 + IW'(i));
    wait_drain("stream");
    check("stream_no_stall", OW'(stalls), OW'(0));
    check("stream_read_cnt", OW'(read_cnt), OW'(100));
    check("stream_pops", OW'(n_pop - p0), OW'(100));

    // 3. Full backpressure
    do_reset();
    rdy_b  = 1'b0;
    stalls = 0;
    p0 = n_pop;
    for (int i = 0; i < 136; i++) send_beat(32'h3000_0000 + IW'(i));
    check("bp_no_early_stall", OW'(stalls), OW'(0));
    check("bp_rdy_a_low", OW'(rdy_a), OW'(0));
    vld_a = 1'b1;
    d_a   = 32'hDEAD_BEEF;
    #1;
    check("bp_stall_cond", OW'(stall), OW'(1));
    c0 = full_cnt;
    repeat (5) begin @(posedge clk); #1; end
    check("bp_full_cnt_delta", OW'(full_cnt - c0), OW'(5));
    check("bp_rdy_a_still_low", OW'(rdy_a), OW'(0));
    vld_a = 1'b0;
    rdy_b = 1'b1;
    @(posedge clk); #1;
    check("bp_rdy_a_rise", OW'(rdy_a), OW'(1));
    wait_drain("bp");
    check("bp_read_cnt", OW'(read_cnt), OW'(34));
    check("bp_pops", OW'(n_pop - p0), OW'(34));

    // 4. Partial hold and asynchronous reset
    do_reset();
    rdy_b = 1'b1;
    for (int i = 1; i <= 3; i++) send_beat(32'h4000_0000 + IW'(i));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("partial_vld_b", OW'(vld_b), OW'(0));
    end
    check("pre_rst_empty_cnt_nonzero", OW'(empty_cnt != 0), OW'(1));
    #3 rst_n = 1'b0;
    #1;
    check("async_full_cnt", OW'(full_cnt), OW'(0));
    check("async_empty_cnt", OW'(empty_cnt), OW'(0));
    check("async_read_cnt", OW'(read_cnt), OW'(0));
    check("async_vld_b", OW'(vld_b), OW'(0));
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    send_beat(32'hA); send_beat(32'hB); send_beat(32'hC); send_beat(32'hD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_rst_vld_b", OW'(vld_b), OW'(1));
    check("post_rst_word", d_b, 128'h0000000D_0000000C_0000000B_0000000A);
    wait_drain("partial");

    // 5. Counter freeze
    do_reset();
    rdy_b = 1'b1;
    @(posedge clk); #1;
    done_mode = 1'b1;
    c0 = empty_cnt;
    repeat (10) begin @(posedge clk); #1; end
    check("freeze_empty_cnt", OW'(empty_cnt), OW'(c0));
    check("freeze_stall_op", OW'(stall), OW'(0));
    check("freeze_stall_ip", OW'(stall2), OW'(0));
    done_mode = 1'b0;
    #1;
    check("unfreeze_stall_ip", OW'(stall2), OW'(1));
    @(posedge clk); #1;
    check("unfreeze_empty_cnt", OW'(empty_cnt), OW'(c0 + 1));

    // 6. Random output stall
    do_reset();
    p0   = n_pop;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send_beat(32'h6000_0000 + IW'(i * 7));
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          rdy_b = 1'($urandom_range(0, 1));
        end
      end
    join
    rdy_b = 1'b1;
    wait_drain("rand");
    check("rand_pops", OW'(n_pop - p0), OW'(50));

    check("sb_final_empty", OW'(sb.size()), OW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
